// File: rtl/dmem_if.sv
// Bundle of the CPU MEM-stage port, the debug/loader port and the SRAM port
// that meet at the data-memory arbiter.
interface dmem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment side: requesters plus the SRAM
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage, debug port) arbiter in front of a single-port
// synchronous SRAM; round-robin on ties, one stall cycle per CPU load.
//
// state  | meaning
// IDLE   | arbitrate and issue at most one access this cycle
// CPU_RD | SRAM returning CPU load data; load completes, stall released
// DBG_RD | SRAM returning debug load data; dbg_rvalid pulses
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic  clk,
    input logic  rst,
    dmem_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_dbg;
    logic              last_dbg_nxt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              grant_cpu;
    logic              grant_dbg;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_stall;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] dbg_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_dbg    <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state    <= state_nxt;
            last_dbg <= last_dbg_nxt;
            if (state == CPU_RD) cpu_rdata_q <= bus.mem_rdata;
            if (state == DBG_RD) dbg_rdata_q <= bus.mem_rdata;
        end
    end

    // Everything is gated by rst so requests seen during reset have no effect.
    always_comb begin
        state_nxt    = state;
        last_dbg_nxt = last_dbg;
        grant_cpu    = 1'b0;
        grant_dbg    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cpu_stall    = 1'b0;
        dbg_gnt      = 1'b0;
        dbg_rvalid   = 1'b0;
        cpu_rdata    = cpu_rdata_q;
        dbg_rdata    = dbg_rdata_q;
        if (!rst) begin
            case (state)
                IDLE: begin
                    grant_dbg = bus.dbg_req && (!bus.cpu_req || !last_dbg);
                    grant_cpu = bus.cpu_req && !grant_dbg;
                    if (grant_dbg) begin
                        mem_en       = 1'b1;
                        mem_we       = bus.dbg_we;
                        mem_addr     = bus.dbg_addr;
                        mem_wdata    = bus.dbg_wdata;
                        dbg_gnt      = 1'b1;
                        cpu_stall    = bus.cpu_req;
                        last_dbg_nxt = 1'b1;
                        if (!bus.dbg_we) state_nxt = DBG_RD;
                    end else if (grant_cpu) begin
                        mem_en       = 1'b1;
                        mem_we       = bus.cpu_we;
                        mem_addr     = bus.cpu_addr;
                        mem_wdata    = bus.cpu_wdata;
                        last_dbg_nxt = 1'b0;
                        if (!bus.cpu_we) begin
                            cpu_stall = 1'b1;
                            state_nxt = CPU_RD;
                        end
                    end
                end
                CPU_RD: begin
                    // The pending CPU request is the completing load itself.
                    cpu_rdata = bus.mem_rdata;
                    state_nxt = IDLE;
                end
                DBG_RD: begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = bus.mem_rdata;
                    cpu_stall  = bus.cpu_req;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.cpu_stall  = cpu_stall;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_rvalid = dbg_rvalid;
    assign bus.dbg_rdata  = dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus hand-written reset/tie sequences for dmem_arbiter,
// with a small synchronous SRAM model on the memory port.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit [31:0] sram [256];
    bit [31:0] rdata_q;
    assign bus.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (rst) begin
            sram[8'h10] <= 32'hDEAD_BEEF;
            sram[8'h12] <= 32'h1234_5678;
        end else if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            else            rdata_q <= sram[bus.mem_addr[9:2]];
        end
    end

    typedef struct {
        logic        rst;
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic        e_en, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall, e_gnt, e_rvalid;
        logic [31:0] e_crdata, e_drdata;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(
        logic r, logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
        logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
        logic en, logic we, logic [31:0] a, logic [31:0] wd,
        logic st, logic g, logic rv, logic [31:0] crd, logic [31:0] drd);
        vec_t v;
        v.rst = r;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        v.e_en = en; v.e_we = we; v.e_addr = a; v.e_wdata = wd;
        v.e_stall = st; v.e_gnt = g; v.e_rvalid = rv;
        v.e_crdata = crd; v.e_drdata = drd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] D48  = 32'h1234_5678;

    initial begin
        int stall_cnt;
        bit fell;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        next_cycle();

        //              rst cpu:req we addr       wdata  dbg:req we addr      wdata   exp:en we addr     wdata st g rv cpu_rdata dbg_rdata
        vecs.push_back(mk(1, 1,0,32'h040,32'h0,   1,0,32'h048,32'h0,   0,0,32'h000,32'h00, 0,0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1,1,32'h100,32'h1,   0,0,32'h000,32'h0,   1,1,32'h100,32'h01, 0,0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1,0,32'h040,32'h0,   0,0,32'h000,32'h0,   1,0,32'h040,32'h00, 1,0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1,0,32'h040,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 0,0,32'h000,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, BEEF,  32'h0));
        // continuous store contention: dbg, cpu, dbg, cpu, dbg, cpu
        vecs.push_back(mk(0, 1,1,32'h200,32'hA0,  1,1,32'h300,32'hD0,  1,1,32'h300,32'hD0, 1,1,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h200,32'hA0,  1,1,32'h304,32'hD1,  1,1,32'h200,32'hA0, 0,0,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h204,32'hA1,  1,1,32'h304,32'hD1,  1,1,32'h304,32'hD1, 1,1,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h204,32'hA1,  1,1,32'h308,32'hD2,  1,1,32'h204,32'hA1, 0,0,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h208,32'hA2,  1,1,32'h308,32'hD2,  1,1,32'h308,32'hD2, 1,1,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h208,32'hA2,  1,1,32'h30C,32'hD3,  1,1,32'h208,32'hA2, 0,0,0, BEEF,  32'h0));
        // CPU load loses to debug store, then cancels
        vecs.push_back(mk(0, 1,0,32'h044,32'h0,   1,1,32'h310,32'hD4,  1,1,32'h310,32'hD4, 1,1,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 0,0,32'h000,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, BEEF,  32'h0));
        // debug load, CPU store waits out DBG_RD
        vecs.push_back(mk(0, 0,0,32'h000,32'h0,   1,0,32'h048,32'h0,   1,0,32'h048,32'h00, 0,1,0, BEEF,  32'h0));
        vecs.push_back(mk(0, 1,1,32'h400,32'h77,  0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 1,0,1, BEEF,  D48));
        vecs.push_back(mk(0, 1,1,32'h400,32'h77,  0,0,32'h000,32'h0,   1,1,32'h400,32'h77, 0,0,0, BEEF,  D48));
        vecs.push_back(mk(0, 0,0,32'h000,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, BEEF,  D48));
        // read back the first store
        vecs.push_back(mk(0, 1,0,32'h100,32'h0,   0,0,32'h000,32'h0,   1,0,32'h100,32'h00, 1,0,0, BEEF,  D48));
        vecs.push_back(mk(0, 1,0,32'h100,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, 32'h1, D48));
        vecs.push_back(mk(0, 0,0,32'h000,32'h0,   0,0,32'h000,32'h0,   0,0,32'h000,32'h00, 0,0,0, 32'h1, D48));

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
                  vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
            @(negedge clk);
            chk($sformatf("v%0d mem_en", i),     {31'b0, bus.mem_en},     {31'b0, vecs[i].e_en});
            chk($sformatf("v%0d mem_we", i),     {31'b0, bus.mem_we},     {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d mem_addr", i),   bus.mem_addr,            vecs[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i),  bus.mem_wdata,           vecs[i].e_wdata);
            chk($sformatf("v%0d cpu_stall", i),  {31'b0, bus.cpu_stall},  {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d dbg_gnt", i),    {31'b0, bus.dbg_gnt},    {31'b0, vecs[i].e_gnt});
            chk($sformatf("v%0d dbg_rvalid", i), {31'b0, bus.dbg_rvalid}, {31'b0, vecs[i].e_rvalid});
            chk($sformatf("v%0d cpu_rdata", i),  bus.cpu_rdata,           vecs[i].e_crdata);
            chk($sformatf("v%0d dbg_rdata", i),  bus.dbg_rdata,           vecs[i].e_drdata);
            next_cycle();
        end

        // Both loads on the first cycle after reset: debug first, CPU stalls 3 cycles total.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(1, 0, 32'h040, 0, 1, 0, 32'h048, 0);
        @(negedge clk);
        chk("tie dbg_gnt",        {31'b0, bus.dbg_gnt},   32'd1);
        chk("tie mem_addr",       bus.mem_addr,           32'h048);
        chk("tie reset cpu_rdata", bus.cpu_rdata,         32'h0);
        chk("tie reset dbg_rdata", bus.dbg_rdata,         32'h0);
        stall_cnt = bus.cpu_stall ? 1 : 0;
        next_cycle();
        drive(1, 0, 32'h040, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("tie dbg_rvalid",     {31'b0, bus.dbg_rvalid}, 32'd1);
        chk("tie dbg_rdata",      bus.dbg_rdata,           D48);
        chk("tie dbg_gnt once",   {31'b0, bus.dbg_gnt},    32'd0);
        if (bus.cpu_stall) stall_cnt++;
        fell = 1'b0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            if (!bus.cpu_stall) begin
                fell = 1'b1;
                break;
            end
            stall_cnt++;
        end
        chk("tie stall fell",     {31'b0, fell},   32'd1);
        chk("tie stall count",    stall_cnt,       32'd3);
        chk("tie cpu_rdata",      bus.cpu_rdata,   BEEF);
        next_cycle();

        // Reset while in CPU_RD, then first tie goes to debug.
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstrd issue stall",  {31'b0, bus.cpu_stall}, 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstrd cpu_stall",    {31'b0, bus.cpu_stall},  32'd0);
        chk("rstrd dbg_gnt",      {31'b0, bus.dbg_gnt},    32'd0);
        chk("rstrd dbg_rvalid",   {31'b0, bus.dbg_rvalid}, 32'd0);
        chk("rstrd mem_en",       {31'b0, bus.mem_en},     32'd0);
        chk("rstrd mem_we",       {31'b0, bus.mem_we},     32'd0);
        chk("rstrd mem_addr",     bus.mem_addr,            32'h0);
        chk("rstrd mem_wdata",    bus.mem_wdata,           32'h0);
        chk("rstrd cpu_rdata",    bus.cpu_rdata,           32'h0);
        chk("rstrd dbg_rdata",    bus.dbg_rdata,           32'h0);
        next_cycle();
        drive(1, 1, 32'h500, 32'h1, 1, 1, 32'h504, 32'h2);
        @(negedge clk);
        chk("rstrd tie dbg_gnt",  {31'b0, bus.dbg_gnt},    32'd1);
        chk("rstrd tie mem_addr", bus.mem_addr,            32'h504);
        chk("rstrd tie stall",    {31'b0, bus.cpu_stall},  32'd1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port cpu_req  input  1  pipeline MEM-stage access request (load or store).
REQ-005 SHALL have port cpu_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports cpu_addr  input  ADDR_W  and cpu_wdata  input  DATA_W  MEM-stage address and store data.
REQ-007 SHALL have port cpu_rdata  output  DATA_W  load data, valid in the cycle cpu_stall falls after a load.
REQ-008 SHALL have port cpu_stall  output  1  freezes pipeline stages IF..MEM while high.
REQ-009 SHALL have ports dbg_req  input  1, dbg_we  input  1, dbg_addr  input  ADDR_W, dbg_wdata  input  DATA_W  debug/loader port, held stable until granted.
REQ-010 SHALL have ports dbg_gnt  output  1  one-cycle grant pulse; dbg_rvalid  output  1; dbg_rdata  output  DATA_W.
REQ-011 SHALL have ports mem_en, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  (synchronous SRAM, read data one cycle after mem_en with mem_we=0).

Function
REQ-012 SHALL implement FSM states IDLE, CPU_RD, DBG_RD.
REQ-013 IDLE: SHALL issue at most one memory access per cycle; mem_en=1 only in the issue cycle of a granted request.
REQ-014 Arbitration in IDLE: one requester only -> grant it; both -> grant the requester not granted most recently (last_grant bit, reset value CPU, so debug wins the first tie).
REQ-015 CPU store granted: mem_we=1 same cycle, cpu_stall=0, FSM stays IDLE (zero added latency).
REQ-016 CPU load granted: cpu_stall=1 in the issue cycle, FSM -> CPU_RD; in CPU_RD cpu_stall=0, cpu_rdata=mem_rdata, FSM -> IDLE (load latency 1 stall cycle).
REQ-017 CPU request losing arbitration: cpu_stall=1 for that cycle; no CPU memory access that cycle.
REQ-018 Debug granted: dbg_gnt=1 for exactly the issue cycle; store -> stay IDLE; load -> DBG_RD, next cycle dbg_rvalid=1, dbg_rdata=mem_rdata, -> IDLE.
REQ-019 In CPU_RD and DBG_RD no new access SHALL be issued; a pending CPU request in those states SHALL see cpu_stall=1, except REQ-016's completion cycle, where cpu_stall=0 for the completing load only.
REQ-020 cpu_rdata and dbg_rdata SHALL hold their last captured value until the next load completion on the same port.
REQ-021 Round-robin guarantee: with both requesters continuously asserting, grants SHALL alternate; no requester waits more than one access (<=2 cycles for a load ahead of it).
REQ-022 mem_addr/mem_wdata SHALL be driven from the granted requester; when mem_en=0 they SHALL be zero.
REQ-023 cpu_req deasserting while stalled by lost arbitration SHALL cancel the request with no memory side effect.

Reset
REQ-024 rst in any state SHALL abort any outstanding load, force FSM to IDLE, last_grant=CPU, and the next cycle SHALL show cpu_stall=0, dbg_gnt=0, dbg_rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dbg_rdata=0.
REQ-025 Requests present during rst SHALL be ignored; arbitration resumes in the first cycle after rst falls.

Verification
REQ-026 CPU store alone, addr 0x100 data 1 -> same cycle mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=1, cpu_stall=0.
REQ-027 CPU load alone, addr 0x40, SRAM[0x40]=0xDEADBEEF -> cpu_stall=1 one cycle, next cycle cpu_stall=0, cpu_rdata=0xDEADBEEF.
REQ-028 CPU and debug loads both asserted first cycle after reset -> debug granted first (dbg_gnt pulse, dbg_rvalid next cycle), CPU stalled 2 cycles, then served; total CPU stall 3 cycles.
REQ-029 Both requesters assert stores continuously for 6 cycles -> grants alternate dbg, cpu, dbg, cpu, dbg, cpu; cpu_stall high exactly on debug-grant cycles.
REQ-030 rst asserted in CPU_RD -> next cycle all outputs zero, no cpu_rdata update, no dbg_rvalid; first post-reset tie granted to debug.
REQ-031 CPU load stalled by debug grant, cpu_req dropped next cycle -> no CPU mem_en issued, cpu_stall=0.
